rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 54 +++++
 rtl/rom_region_decode.sv | 39 +++
 rtl/rom_loader.sv | 127 ++++++++++++
 tb/tb_rom_loader.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader_pkg
//  Description : Shared types and constants for the boot ROM loader: FSM
//                state encoding, destination region enum and the address
//                windows (base/limit, inclusive) of every internal RAM.
//  Revision    : 1.0  initial release
// ============================================================================
package rom_loader_pkg;

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        RGN_NONE = 4'd0,
        RGN_BG   = 4'd1,
        RGN_CPU2 = 4'd2,
        RGN_PAL1 = 4'd3,
        RGN_PAL3 = 4'd4,
        RGN_CLUT = 4'd5,
        RGN_WAV  = 4'd6,
        RGN_SPR1 = 4'd7,
        RGN_SPR2 = 4'd8
    } region_t;

    localparam logic [16:0] c_BG_BASE    = 17'h0A000;
    localparam logic [16:0] c_BG_LIMIT   = 17'h0AFFF;
    localparam logic [16:0] c_CPU2_BASE  = 17'h08000;
    localparam logic [16:0] c_CPU2_LIMIT = 17'h09FFF;
    localparam logic [16:0] c_PAL1_BASE  = 17'h0B400;
    localparam logic [16:0] c_PAL1_LIMIT = 17'h0B4FF;
    localparam logic [16:0] c_PAL3_BASE  = 17'h0B000;
    localparam logic [16:0] c_PAL3_LIMIT = 17'h0B3FF;
    localparam logic [16:0] c_CLUT_BASE  = 17'h0B600;
    localparam logic [16:0] c_CLUT_LIMIT = 17'h0B61F;
    localparam logic [16:0] c_WAV_BASE   = 17'h0B500;
    localparam logic [16:0] c_WAV_LIMIT  = 17'h0B5FF;
    localparam logic [16:0] c_SPR1_BASE  = 17'h10000;
    localparam logic [16:0] c_SPR1_LIMIT = 17'h13FFF;
    localparam logic [16:0] c_SPR2_BASE  = 17'h14000;
    localparam logic [16:0] c_SPR2_LIMIT = 17'h17FFF;

    function automatic logic in_window(input logic [16:0] addr,
                                       input logic [16:0] base,
                                       input logic [16:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rom_region_decode.sv
`default_nettype none
// ============================================================================
//  Module      : rom_region_decode
//  Description : Combinational decode of a 17-bit load address into the
//                destination RAM region. Windows do not overlap, so the
//                result is unique; unmapped addresses give RGN_NONE.
//  Ports       : addr   in  17  load address
//                region out  4  decoded region_t
//  Revision    : 1.0  initial release
// ============================================================================
module rom_region_decode
    import rom_loader_pkg::*;
(
    input  logic [16:0] addr,
    output region_t     region
);

    always_comb begin
        region = RGN_NONE;
        if (in_window(addr, c_BG_BASE, c_BG_LIMIT))
            region = RGN_BG;
        else if (in_window(addr, c_CPU2_BASE, c_CPU2_LIMIT))
            region = RGN_CPU2;
        else if (in_window(addr, c_PAL1_BASE, c_PAL1_LIMIT))
            region = RGN_PAL1;
        else if (in_window(addr, c_PAL3_BASE, c_PAL3_LIMIT))
            region = RGN_PAL3;
        else if (in_window(addr, c_CLUT_BASE, c_CLUT_LIMIT))
            region = RGN_CLUT;
        else if (in_window(addr, c_WAV_BASE, c_WAV_LIMIT))
            region = RGN_WAV;
        else if (in_window(addr, c_SPR1_BASE, c_SPR1_LIMIT))
            region = RGN_SPR1;
        else if (in_window(addr, c_SPR2_BASE, c_SPR2_LIMIT))
            region = RGN_SPR2;
    end

endmodule
`default_nettype wire

// File: rtl/rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : rom_loader
//  Description : Boot-time copier. Walks the external ROM from START_ADDR to
//                END_ADDR one byte at a time (ISSUE, RD_LAT wait cycles,
//                WRITE), forwards each byte to the internal RAM selected by
//                the address region with a one-cycle strobe, and keeps a
//                16-bit running checksum. romtrans_done holds until reset.
//  Ports       : clk_6144      in   1   clock
//                reset         in   1   synchronous active-high reset
//                rom_a         out 19   external ROM address (0 when done)
//                rom_d         in   8   external ROM data
//                dl_addr       out 14   region-local write offset
//                dl_data       out  8   write data
//                we_*          out  1   per-RAM write strobes (one-hot)
//                romtrans_done out  1   copy complete
//                checksum      out 16   sum of all bytes read, mod 2^16
//  Revision    : 1.0  initial release
// ============================================================================
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int unsigned RD_LAT     = 1,
    parameter logic [16:0] END_ADDR   = 17'h1FFFF,
    // Address loaded on reset; 0 for the real boot sequence.
    parameter logic [16:0] START_ADDR = 17'h00000
) (
    input  logic        clk_6144,
    input  logic        reset,
    output logic [18:0] rom_a,
    input  logic [7:0]  rom_d,
    output logic [13:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        we_bg,
    output logic        we_cpu2,
    output logic        we_palrom1,
    output logic        we_palrom3,
    output logic        we_clut,
    output logic        we_wavrom,
    output logic        we_spr1,
    output logic        we_spr2,
    output logic        romtrans_done,
    output logic [15:0] checksum
);

    localparam bit          c_HAS_WAIT  = (RD_LAT != 0);
    localparam int          c_LAT_M1    = (RD_LAT > 0) ? int'(RD_LAT) - 1 : 0;
    localparam logic [2:0]  c_WAIT_LAST = 3'(c_LAT_M1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [16:0] r_addr;
    logic [2:0]  r_wait_cnt;
    logic [13:0] r_dl_addr;
    logic [7:0]  r_dl_data;
    logic [15:0] r_checksum;
    // Region of the byte written last cycle; RGN_NONE means no strobe.
    region_t     r_region;
    region_t     w_region;
    logic        w_wait_done;
    logic        w_last_byte;

    rom_region_decode u_decode (
        .addr   (r_addr),
        .region (w_region)
    );

    assign w_wait_done = (r_wait_cnt == c_WAIT_LAST);
    assign w_last_byte = (r_addr == END_ADDR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ISSUE: w_state_nxt = c_HAS_WAIT ? ST_WAIT : ST_WRITE;
            ST_WAIT:  if (w_wait_done) w_state_nxt = ST_WRITE;
            ST_WRITE: w_state_nxt = w_last_byte ? ST_DONE : ST_ISSUE;
            default:  w_state_nxt = ST_DONE;
        endcase
    end

    always_ff @(posedge clk_6144) begin
        if (reset) begin
            r_state    <= ST_ISSUE;
            r_addr     <= START_ADDR;
            r_wait_cnt <= 3'd0;
            r_dl_addr  <= 14'd0;
            r_dl_data  <= 8'd0;
            r_checksum <= 16'd0;
            r_region   <= RGN_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_region <= RGN_NONE;
            case (r_state)
                ST_WAIT: r_wait_cnt <= w_wait_done ? 3'd0 : r_wait_cnt + 3'd1;
                ST_WRITE: begin
                    r_dl_data  <= rom_d;
                    r_dl_addr  <= r_addr[13:0];
                    r_checksum <= r_checksum + {8'h00, rom_d};
                    r_region   <= w_region;
                    // Address stops at END_ADDR so it can never wrap.
                    if (!w_last_byte)
                        r_addr <= r_addr + 17'd1;
                end
                default: ;
            endcase
        end
    end

    // The strobe for the final byte, if it falls in a region, lands in the
    // first DONE cycle; with the default END_ADDR it is unmapped.
    assign rom_a         = (r_state == ST_DONE) ? 19'd0 : {2'b00, r_addr};
    assign dl_addr       = r_dl_addr;
    assign dl_data       = r_dl_data;
    assign checksum      = r_checksum;
    assign romtrans_done = (r_state == ST_DONE);

    assign we_bg      = (r_region == RGN_BG);
    assign we_cpu2    = (r_region == RGN_CPU2);
    assign we_palrom1 = (r_region == RGN_PAL1);
    assign we_palrom3 = (r_region == RGN_PAL3);
    assign we_clut    = (r_region == RGN_CLUT);
    assign we_wavrom  = (r_region == RGN_WAV);
    assign we_spr1    = (r_region == RGN_SPR1);
    assign we_spr2    = (r_region == RGN_SPR2);

endmodule
`default_nettype wire

// File: tb/tb_rom_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rom_loader
//  Description : Self-checking bench for rom_loader. Three instances share
//                one clock: A (RD_LAT=1) copies 0x0A000..0x0B630 across the
//                bg/palette/wave/clut windows, S (RD_LAT=1) straddles the
//                spr1/spr2 split, Z (RD_LAT=0) copies 0x0..0xF.
//                Model ROM byte = addr[7:0] ^ addr[15:8].
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rom_loader;
    import rom_loader_pkg::*;

    localparam logic [16:0] A_START = 17'h0A000;
    localparam logic [16:0] A_END   = 17'h0B630;
    localparam int          A_N     = 5681;        // 0x1631 bytes
    localparam logic [16:0] S_START = 17'h13FF0;
    localparam logic [16:0] S_END   = 17'h1400F;
    localparam logic [16:0] Z_END   = 17'h0000F;

    logic clk_6144 = 1'b0;
    always #5 clk_6144 = ~clk_6144;

    int n_pass  = 0;
    int n_total = 0;
    bit fin_a = 0, fin_s = 0, fin_z = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] rom_byte(input logic [16:0] a);
        return a[7:0] ^ a[15:8];
    endfunction

    function automatic logic [15:0] model_sum(input logic [16:0] lo, input logic [16:0] hi);
        logic [15:0] s;
        s = '0;
        for (int a = int'(lo); a <= int'(hi); a++) s += {8'h00, rom_byte(17'(a))};
        return s;
    endfunction

    // Strobe vector bit order: 0 bg,1 cpu2,2 pal1,3 pal3,4 clut,5 wav,6 spr1,7 spr2
    function automatic logic [7:0] rgn_vec(input region_t r);
        case (r)
            RGN_BG:   return 8'h01;
            RGN_CPU2: return 8'h02;
            RGN_PAL1: return 8'h04;
            RGN_PAL3: return 8'h08;
            RGN_CLUT: return 8'h10;
            RGN_WAV:  return 8'h20;
            RGN_SPR1: return 8'h40;
            RGN_SPR2: return 8'h80;
            default:  return 8'h00;
        endcase
    endfunction

    // ---------------- instance A ----------------
    logic        reset_a;
    logic [18:0] rom_a_a;
    logic [7:0]  rom_d_a;
    logic [13:0] dl_addr_a;
    logic [7:0]  dl_data_a;
    logic        bg_a, cpu2_a, pal1_a, pal3_a, clut_a, wav_a, spr1_a, spr2_a;
    logic        done_a;
    logic [15:0] checksum_a;
    logic [7:0]  vec_a;
    region_t     ref_rgn_a;

    rom_loader #(.RD_LAT(1), .END_ADDR(A_END), .START_ADDR(A_START)) u_dut_a (
        .clk_6144(clk_6144), .reset(reset_a), .rom_a(rom_a_a), .rom_d(rom_d_a),
        .dl_addr(dl_addr_a), .dl_data(dl_data_a), .we_bg(bg_a), .we_cpu2(cpu2_a),
        .we_palrom1(pal1_a), .we_palrom3(pal3_a), .we_clut(clut_a), .we_wavrom(wav_a),
        .we_spr1(spr1_a), .we_spr2(spr2_a), .romtrans_done(done_a), .checksum(checksum_a)
    );
    always @(posedge clk_6144) rom_d_a <= rom_byte(rom_a_a[16:0]);
    assign vec_a = {spr2_a, spr1_a, wav_a, clut_a, pal3_a, pal1_a, cpu2_a, bg_a};

    // Whole A window lies in 0x08000-0x0BFFF, so addr[16:14] = 3'b010.
    rom_region_decode u_ref_a (.addr({3'b010, dl_addr_a}), .region(ref_rgn_a));

    int         cnt_a [8];
    int         tot_a, multi_a, sb_err_a;
    logic [7:0] k33ff, d33ff, k3400, d3400, k361f, k3620;

    always @(negedge clk_6144) begin
        if (vec_a != 8'h00) begin
            tot_a++;
            for (int b = 0; b < 8; b++) if (vec_a[b]) cnt_a[b]++;
            if (vec_a != rgn_vec(ref_rgn_a)) sb_err_a++;
            if (dl_addr_a == 14'h33FF) begin k33ff = vec_a; d33ff = dl_data_a; end
            if (dl_addr_a == 14'h3400) begin k3400 = vec_a; d3400 = dl_data_a; end
            if (dl_addr_a == 14'h361F) k361f = vec_a;
        end
        if ($countones(vec_a) > 1) multi_a++;
        if (dl_addr_a == 14'h3620) k3620 = k3620 | vec_a;
    end

    task automatic clear_a();
        foreach (cnt_a[i]) cnt_a[i] = 0;
        tot_a = 0; multi_a = 0; sb_err_a = 0;
        k33ff = 0; d33ff = 0; k3400 = 0; d3400 = 0; k361f = 0; k3620 = 0;
    endtask

    task automatic run_a(input string tag);
        int cyc;
        cyc = 0;
        while (!done_a && cyc < 3 * A_N + 20) begin
            @(posedge clk_6144); #1;
            cyc++;
        end
        chk({tag, "_done_cycle"}, cyc, 3 * A_N);
        repeat (2) @(posedge clk_6144);
        #1;
    endtask

    initial begin
        logic [15:0] sum_a;
        sum_a = model_sum(A_START, A_END);
        clear_a();
        reset_a = 1'b1;
        repeat (3) @(posedge clk_6144);
        #1;
        chk("a_rst_rom_a",    rom_a_a,    {2'b00, A_START});
        chk("a_rst_dl_addr",  dl_addr_a,  0);
        chk("a_rst_dl_data",  dl_data_a,  0);
        chk("a_rst_strobes",  vec_a,      0);
        chk("a_rst_done",     done_a,     0);
        chk("a_rst_checksum", checksum_a, 0);
        reset_a = 1'b0;

        // Byte 16 (0x0A010) is in WRITE between edges 50 and 51.
        repeat (50) @(posedge clk_6144);
        #1;
        chk("a_mid_rom_a",  rom_a_a,  19'h0A010);
        chk("a_mid_bg_cnt", cnt_a[0], 16);
        reset_a = 1'b1;
        @(posedge clk_6144); #1;
        reset_a = 1'b0;
        chk("a_abort_strobe",   vec_a,      0);
        chk("a_abort_rom_a",    rom_a_a,    {2'b00, A_START});
        chk("a_abort_checksum", checksum_a, 0);
        clear_a();

        run_a("a_run1");
        chk("a_cnt_bg",    cnt_a[0], 4096);
        chk("a_cnt_cpu2",  cnt_a[1], 0);
        chk("a_cnt_pal1",  cnt_a[2], 256);
        chk("a_cnt_pal3",  cnt_a[3], 1024);
        chk("a_cnt_clut",  cnt_a[4], 32);
        chk("a_cnt_wav",   cnt_a[5], 256);
        chk("a_cnt_total", tot_a,    5664);
        chk("a_multi",     multi_a,  0);
        chk("a_scoreboard", sb_err_a, 0);
        chk("a_checksum",  checksum_a, sum_a);
        chk("a_b3ff_strobe", k33ff, 8'h08);
        chk("a_b3ff_data",   d33ff, 8'h4C);
        chk("a_b400_strobe", k3400, 8'h04);
        chk("a_b400_data",   d3400, 8'hB4);
        chk("a_b61f_strobe", k361f, 8'h10);
        chk("a_b620_strobe", k3620, 8'h00);
        repeat (5) @(posedge clk_6144);
        #1;
        chk("a_done_hold",     done_a,     1);
        chk("a_done_rom_a",    rom_a_a,    0);
        chk("a_done_strobes",  vec_a,      0);
        chk("a_done_checksum", checksum_a, sum_a);

        reset_a = 1'b1;
        @(posedge clk_6144); #1;
        chk("a_redo_done_clr",  done_a,     0);
        chk("a_redo_checksum0", checksum_a, 0);
        reset_a = 1'b0;
        clear_a();
        run_a("a_run2");
        chk("a_redo_checksum", checksum_a, sum_a);
        chk("a_redo_total",    tot_a,      5664);
        fin_a = 1;
    end

    // ---------------- instance S ----------------
    logic        reset_s;
    logic [18:0] rom_a_s;
    logic [7:0]  rom_d_s;
    logic [13:0] dl_addr_s;
    logic [7:0]  dl_data_s;
    logic        bg_s, cpu2_s, pal1_s, pal3_s, clut_s, wav_s, spr1_s, spr2_s;
    logic        done_s;
    logic [15:0] checksum_s;
    logic [7:0]  vec_s;

    rom_loader #(.RD_LAT(1), .END_ADDR(S_END), .START_ADDR(S_START)) u_dut_s (
        .clk_6144(clk_6144), .reset(reset_s), .rom_a(rom_a_s), .rom_d(rom_d_s),
        .dl_addr(dl_addr_s), .dl_data(dl_data_s), .we_bg(bg_s), .we_cpu2(cpu2_s),
        .we_palrom1(pal1_s), .we_palrom3(pal3_s), .we_clut(clut_s), .we_wavrom(wav_s),
        .we_spr1(spr1_s), .we_spr2(spr2_s), .romtrans_done(done_s), .checksum(checksum_s)
    );
    always @(posedge clk_6144) rom_d_s <= rom_byte(rom_a_s[16:0]);
    assign vec_s = {spr2_s, spr1_s, wav_s, clut_s, pal3_s, pal1_s, cpu2_s, bg_s};

    int         spr1_cnt = 0, spr2_cnt = 0, tot_s = 0, multi_s = 0;
    logic [7:0] k3fff = 0, d3fff = 0, k0000 = 0, d0000 = 0;

    always @(negedge clk_6144) begin
        if (vec_s != 8'h00) begin
            tot_s++;
            if (spr1_s) spr1_cnt++;
            if (spr2_s) spr2_cnt++;
            if (dl_addr_s == 14'h3FFF) begin k3fff = vec_s; d3fff = dl_data_s; end
            if (dl_addr_s == 14'h0000) begin k0000 = vec_s; d0000 = dl_data_s; end
        end
        if ($countones(vec_s) > 1) multi_s++;
    end

    initial begin
        int cyc;
        reset_s = 1'b1;
        repeat (3) @(posedge clk_6144);
        #1;
        reset_s = 1'b0;
        cyc = 0;
        while (!done_s && cyc < 200) begin
            @(posedge clk_6144); #1;
            cyc++;
        end
        chk("s_done_cycle", cyc, 96);
        repeat (2) @(posedge clk_6144);
        #1;
        chk("s_cnt_spr1",    spr1_cnt, 16);
        chk("s_cnt_spr2",    spr2_cnt, 16);
        chk("s_cnt_total",   tot_s,    32);
        chk("s_multi",       multi_s,  0);
        chk("s_13fff_strobe", k3fff,   8'h40);
        chk("s_13fff_data",   d3fff,   8'hC0);
        chk("s_14000_strobe", k0000,   8'h80);
        chk("s_14000_data",   d0000,   8'h40);
        chk("s_checksum",    checksum_s, model_sum(S_START, S_END));
        fin_s = 1;
    end

    // ---------------- instance Z ----------------
    logic        reset_z;
    logic [18:0] rom_a_z;
    logic [7:0]  rom_d_z;
    logic [13:0] dl_addr_z;
    logic [7:0]  dl_data_z;
    logic        bg_z, cpu2_z, pal1_z, pal3_z, clut_z, wav_z, spr1_z, spr2_z;
    logic        done_z;
    logic [15:0] checksum_z;
    logic [7:0]  vec_z;

    rom_loader #(.RD_LAT(0), .END_ADDR(Z_END)) u_dut_z (
        .clk_6144(clk_6144), .reset(reset_z), .rom_a(rom_a_z), .rom_d(rom_d_z),
        .dl_addr(dl_addr_z), .dl_data(dl_data_z), .we_bg(bg_z), .we_cpu2(cpu2_z),
        .we_palrom1(pal1_z), .we_palrom3(pal3_z), .we_clut(clut_z), .we_wavrom(wav_z),
        .we_spr1(spr1_z), .we_spr2(spr2_z), .romtrans_done(done_z), .checksum(checksum_z)
    );
    assign rom_d_z = rom_byte(rom_a_z[16:0]);
    assign vec_z = {spr2_z, spr1_z, wav_z, clut_z, pal3_z, pal1_z, cpu2_z, bg_z};

    int tot_z = 0;
    always @(negedge clk_6144) if (vec_z != 8'h00) tot_z++;

    initial begin
        int cyc;
        int viol;
        reset_z = 1'b1;
        repeat (3) @(posedge clk_6144);
        #1;
        chk("z_rst_rom_a",    rom_a_z,    0);
        chk("z_rst_dl_addr",  dl_addr_z,  0);
        chk("z_rst_dl_data",  dl_data_z,  0);
        chk("z_rst_done",     done_z,     0);
        chk("z_rst_checksum", checksum_z, 0);
        reset_z = 1'b0;
        cyc = 0;
        while (!done_z && cyc < 100) begin
            @(posedge clk_6144); #1;
            cyc++;
        end
        chk("z_done_cycle", cyc,        32);
        chk("z_checksum",   checksum_z, 16'h0078);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_6144); #1;
            if (!done_z || rom_a_z != 19'd0) viol++;
        end
        chk("z_done_hold_viol", viol,   0);
        chk("z_strobes_total",  tot_z,  0);
        chk("z_checksum_frozen", checksum_z, 16'h0078);
        fin_z = 1;
    end

    // ---------------- summary / watchdog ----------------
    initial begin
        wait (fin_a && fin_s && fin_z);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no completion, expected all sequences finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
